binfo_queue: RTL and testbench

- Parametrised circular branch-information buffer between rename and commit.
- Rename allocates one entry per branch in order, writes the payload that cycle and receives the entry's pack id.
- Execute/resolve reads entries asynchronously by pack id; commit retires entries from the head.
- Mispredict recovery truncates the queue to just after the mispredicting branch; a full flush empties it.

---
 rtl/binfo_queue.sv | 150 +++++++++++++++
 tb/tb_binfo_queue.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binfo_queue.sv
// Circular branch-information queue between rename and commit: in-order allocate,
// async read by pack id, head retire, partial/full flush. Parity: define BINFO_PARITY_EN.
module binfo_queue #(
  parameter  int DEPTH  = 16,
  parameter  int PC_W   = 32,
  localparam int PACK_W = $clog2(DEPTH)
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_n_i,
  input  logic              rn_alloc_i,
  input  logic [PC_W-1:0]   rn_pc_i,
  input  logic [1:0]        rn_bm_pred_i,
  input  logic [1:0]        rn_btype_i,
  input  logic              rn_btb_vld_i,
  input  logic [PC_W-1:0]   rn_btb_target_i,
  input  logic              rn_btb_correct_i,
  input  logic              rn_btb_way_i,
  input  logic              rn_btb_idx_i,
  output logic              rn_ready_o,
  output logic [PACK_W-1:0] rn_pack_o,
  input  logic [PACK_W-1:0] pack_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [1:0]        bm_pred_o,
  output logic [1:0]        btype_o,
  output logic              btb_vld_o,
  output logic [PC_W-1:0]   btb_target_o,
  output logic              btb_correct_o,
  output logic              btb_way_o,
  output logic              btb_idx_o,
  output logic              rd_vld_o,
  output logic              rd_perr_o,
  input  logic              cm_ret_i,
  output logic [PACK_W-1:0] head_pack_o,
  input  logic              flush_i,
  input  logic [PACK_W-1:0] flush_pack_i,
  input  logic              full_flush_i,
  output logic [PACK_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              err_o
);

  localparam int ENT_W = 2 * PC_W + 8;
  localparam logic [PACK_W:0] DEPTH_P = (PACK_W + 1)'(DEPTH);

  logic [PACK_W:0]    head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic               err_q, err_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   wdata, rdata;
  logic [PACK_W-1:0]  head_idx, tail_idx, off;
  logic [PACK_W:0]    count, fp_ptr, keep_cnt;
  logic               full, empty, alloc_ok, ret_ok, fp_wrap;

  assign head_idx = head_q[PACK_W-1:0];
  assign tail_idx = tail_q[PACK_W-1:0];
  assign count    = tail_q - head_q;
  assign full     = (count == DEPTH_P);
  assign empty    = (count == '0);
  assign alloc_ok = rn_alloc_i && !full && !flush_i && !full_flush_i;
  assign ret_ok   = cm_ret_i && !empty && !full_flush_i;

  // Indices below head's index belong to the next lap, so they carry the flipped wrap bit.
  assign fp_wrap  = (flush_pack_i >= head_idx) ? head_q[PACK_W] : ~head_q[PACK_W];
  assign fp_ptr   = {fp_wrap, flush_pack_i};
  assign keep_cnt = fp_ptr + 1'b1 - head_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    err_d  = 1'b0;
    off    = '0;
    if (full_flush_i) begin
      tail_d = head_q;
      vld_d  = '0;
    end else begin
      if (ret_ok) begin
        vld_d[head_idx] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (flush_i) begin
        if (vld_q[flush_pack_i]) begin
          tail_d = fp_ptr + 1'b1;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PACK_W'(i) - head_idx;
            if ({1'b0, off} >= keep_cnt) vld_d[i] = 1'b0;
          end
        end else begin
          err_d = 1'b1;
        end
      end else if (rn_alloc_i) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          vld_d[tail_idx] = 1'b1;
          tail_d          = tail_q + 1'b1;
        end
      end
      if (cm_ret_i && empty) err_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign wdata = {rn_pc_i, rn_bm_pred_i, rn_btype_i, rn_btb_vld_i, rn_btb_target_i,
                  rn_btb_correct_i, rn_btb_way_i, rn_btb_idx_i};

  always_ff @(posedge cpu_clock_i) begin
    if (alloc_ok) mem_q[tail_idx] <= wdata;
  end

  assign rdata = mem_q[pack_i];
  assign {pc_o, bm_pred_o, btype_o, btb_vld_o, btb_target_o,
          btb_correct_o, btb_way_o, btb_idx_o} = rdata;
  assign rd_vld_o = vld_q[pack_i];

`ifdef BINFO_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge cpu_clock_i) begin
    if (alloc_ok) par_q[tail_idx] <= ^wdata;
  end

  assign rd_perr_o = rd_vld_o && ((^rdata) != par_q[pack_i]);
`else
  assign rd_perr_o = 1'b0;
`endif

  assign rn_ready_o  = !full;
  assign rn_pack_o   = tail_idx;
  assign head_pack_o = head_idx;
  assign count_o     = count;
  assign empty_o     = empty;
  assign full_o      = full;
  assign err_o       = err_q;

endmodule

// File: tb/tb_binfo_queue.sv
// Self-checking bench for binfo_queue; expected PCs are queued on allocation and
// popped when the entry is retired from the head.
module tb_binfo_queue;
  localparam int DEPTH  = 16;
  localparam int PC_W   = 32;
  localparam int PACK_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rn_alloc = 1'b0;
  logic [PC_W-1:0]   rn_pc = '0;
  logic [1:0]        rn_bm_pred = '0;
  logic [1:0]        rn_btype = '0;
  logic              rn_btb_vld = 1'b0;
  logic [PC_W-1:0]   rn_btb_target = '0;
  logic              rn_btb_correct = 1'b0;
  logic              rn_btb_way = 1'b0;
  logic              rn_btb_idx = 1'b0;
  logic              rn_ready;
  logic [PACK_W-1:0] rn_pack;
  logic [PACK_W-1:0] pack = '0;
  logic [PC_W-1:0]   pc, btb_target;
  logic [1:0]        bm_pred, btype;
  logic              btb_vld, btb_correct, btb_way, btb_idx;
  logic              rd_vld, rd_perr;
  logic              cm_ret = 1'b0;
  logic [PACK_W-1:0] head_pack;
  logic              flush = 1'b0;
  logic [PACK_W-1:0] flush_pack = '0;
  logic              full_flush = 1'b0;
  logic [PACK_W:0]   count;
  logic              empty, full, err;

  int vectors = 0;
  int miscompares = 0;
  logic [PC_W-1:0] sb[$];
  logic [PC_W-1:0] exp_pc;
  int m_head, m_tail;

  always #5 clk = ~clk;

  binfo_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .cpu_clock_i(clk), .cpu_reset_n_i(rst_n),
    .rn_alloc_i(rn_alloc), .rn_pc_i(rn_pc), .rn_bm_pred_i(rn_bm_pred),
    .rn_btype_i(rn_btype), .rn_btb_vld_i(rn_btb_vld), .rn_btb_target_i(rn_btb_target),
    .rn_btb_correct_i(rn_btb_correct), .rn_btb_way_i(rn_btb_way), .rn_btb_idx_i(rn_btb_idx),
    .rn_ready_o(rn_ready), .rn_pack_o(rn_pack), .pack_i(pack),
    .pc_o(pc), .bm_pred_o(bm_pred), .btype_o(btype), .btb_vld_o(btb_vld),
    .btb_target_o(btb_target), .btb_correct_o(btb_correct), .btb_way_o(btb_way),
    .btb_idx_o(btb_idx), .rd_vld_o(rd_vld), .rd_perr_o(rd_perr),
    .cm_ret_i(cm_ret), .head_pack_o(head_pack), .flush_i(flush),
    .flush_pack_i(flush_pack), .full_flush_i(full_flush),
    .count_o(count), .empty_o(empty), .full_o(full), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rn_alloc = 1'b0; cm_ret = 1'b0; flush = 1'b0; full_flush = 1'b0;
  endtask

  task automatic drive_fields(input logic [PC_W-1:0] p);
    rn_pc = p; rn_bm_pred = p[3:2]; rn_btype = p[5:4]; rn_btb_vld = p[2];
    rn_btb_target = p + 32'h100; rn_btb_correct = p[3]; rn_btb_way = p[4]; rn_btb_idx = p[6];
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
    m_head = 0; m_tail = 0;
  endtask

  task automatic alloc_one(input logic [PC_W-1:0] p);
    rn_alloc = 1'b1;
    drive_fields(p);
    tick();
    rn_alloc = 1'b0;
    sb.push_back(p);
    m_tail++;
  endtask

  task automatic retire_one();
    cm_ret = 1'b1;
    tick();
    cm_ret = 1'b0;
    void'(sb.pop_front());
    m_head++;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({count, empty, full, rn_ready, rn_pack, head_pack, err, rd_vld, rd_perr} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: cnt=%0d empty=%b full=%b rdy=%b pack=%0d head=%0d err=%b vld=%b perr=%b, required cnt=0 empty=1 full=0 rdy=1 pack=0 head=0 err=0 vld=0 perr=0",
               count, empty, full, rn_ready, rn_pack, head_pack, err, rd_vld, rd_perr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_head = 0; m_tail = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      rn_alloc = 1'b1;
      drive_fields(32'h1000 + 32'(4 * i));
      #1;
      vectors++;
      if (rn_pack !== 4'(i)) begin
        miscompares++;
        $display("FAIL fill_pack[%0d]: got %0d, required %0d", i, rn_pack, i);
      end
      tick();
      sb.push_back(32'h1000 + 32'(4 * i));
      m_tail++;
    end
    rn_alloc = 1'b0;
    #1;
    vectors++;
    if ({full, rn_ready, count} !== {1'b1, 1'b0, 5'd16}) begin
      miscompares++;
      $display("FAIL fill_full: full=%b rdy=%b cnt=%0d, required full=1 rdy=0 cnt=16", full, rn_ready, count);
    end
    rn_alloc = 1'b1;
    drive_fields(32'h2000);
    tick();
    rn_alloc = 1'b0;
    vectors++;
    if ({err, count} !== {1'b1, 5'd16}) begin
      miscompares++;
      $display("FAIL alloc_when_full: err=%b cnt=%0d, required err=1 cnt=16", err, count);
    end
    tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse_end: err=%b, required 0", err);
    end
  endtask

  task automatic test_read_retire();
    pack = 4'd5;
    #1;
    vectors++;
    if ({rd_vld, pc, btb_target, bm_pred, btype} !== {1'b1, 32'h1014, 32'h1114, 2'b01, 2'b01}) begin
      miscompares++;
      $display("FAIL read_pack5: vld=%b pc=%h tgt=%h bm=%b bt=%b, required vld=1 pc=00001014 tgt=00001114 bm=01 bt=01",
               rd_vld, pc, btb_target, bm_pred, btype);
    end
    for (int k = 0; k < 3; k++) begin
      pack = 4'(m_head);
      cm_ret = 1'b1;
      #1;
      exp_pc = sb.pop_front();
      vectors++;
      if (pc !== exp_pc) begin
        miscompares++;
        $display("FAIL retire_pc[%0d]: got %h, required %h", k, pc, exp_pc);
      end
      tick();
      m_head++;
    end
    cm_ret = 1'b0;
    pack = 4'd1;
    #1;
    vectors++;
    if ({head_pack, count, rd_vld} !== {4'd3, 5'd13, 1'b0}) begin
      miscompares++;
      $display("FAIL after_retire: head=%0d cnt=%0d vld1=%b, required head=3 cnt=13 vld1=0", head_pack, count, rd_vld);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pack = 4'd5;
    #1;
    vectors++;
    if ({count, empty, rd_vld} !== {5'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL midop_reset: cnt=%0d empty=%b vld5=%b, required cnt=0 empty=1 vld5=0", count, empty, rd_vld);
    end
    for (int i = 0; i < 20; i++) begin
      rn_alloc = 1'b1;
      drive_fields(32'h3000 + 32'(4 * i));
      cm_ret = i[0];
      pack = 4'(m_head);
      #1;
      vectors++;
      if (rn_pack !== 4'(m_tail)) begin
        miscompares++;
        $display("FAIL wrap_pack[%0d]: got %0d, required %0d", i, rn_pack, m_tail % DEPTH);
      end
      if (cm_ret) begin
        vectors++;
        if (pc !== sb[0]) begin
          miscompares++;
          $display("FAIL wrap_ret_pc[%0d]: got %h, required %h", i, pc, sb[0]);
        end
      end
      tick();
      sb.push_back(32'h3000 + 32'(4 * i));
      m_tail++;
      if (cm_ret) begin
        void'(sb.pop_front());
        m_head++;
      end
      vectors++;
      if (count !== 5'(m_tail - m_head)) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: got %0d, required %0d", i, count, m_tail - m_head);
      end
    end
    idle();
    while (m_tail - m_head < DEPTH) alloc_one(32'h3800 + 32'(4 * m_tail));
    vectors++;
    if ({full, empty, rn_ready, count} !== {1'b1, 1'b0, 1'b0, 5'd16}) begin
      miscompares++;
      $display("FAIL wrap_full: full=%b empty=%b rdy=%b cnt=%0d, required 1 0 0 16", full, empty, rn_ready, count);
    end
    rn_alloc = 1'b1;
    drive_fields(32'h4000);
    cm_ret = 1'b1;
    pack = 4'(m_head);
    #1;
    vectors++;
    if (pc !== sb[0]) begin
      miscompares++;
      $display("FAIL full_ret_alloc_pc: got %h, required %h", pc, sb[0]);
    end
    tick();
    idle();
    void'(sb.pop_front());
    m_head++;
    vectors++;
    if ({count, full, rn_pack} !== {5'd15, 1'b0, 4'(m_tail)}) begin
      miscompares++;
      $display("FAIL full_ret_alloc: cnt=%0d full=%b pack=%0d, required cnt=15 full=0 pack=%0d", count, full, rn_pack, m_tail % DEPTH);
    end
    for (int k = 0; k < 15; k++) begin
      pack = 4'(m_head);
      cm_ret = 1'b1;
      #1;
      exp_pc = sb.pop_front();
      vectors++;
      if (pc !== exp_pc) begin
        miscompares++;
        $display("FAIL drain_pc[%0d]: got %h, required %h", k, pc, exp_pc);
      end
      tick();
      m_head++;
    end
    cm_ret = 1'b0;
    vectors++;
    if ({empty, count, head_pack} !== {1'b1, 5'd0, 4'(m_head)}) begin
      miscompares++;
      $display("FAIL wrap_empty: empty=%b cnt=%0d head=%0d, required 1 0 %0d", empty, count, head_pack, m_head % DEPTH);
    end
    cm_ret = 1'b1;
    tick();
    cm_ret = 1'b0;
    vectors++;
    if ({err, count} !== {1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL retire_when_empty: err=%b cnt=%0d, required err=1 cnt=0", err, count);
    end
  endtask

  task automatic test_partial_flush();
    do_reset();
    for (int i = 0; i < 12; i++) alloc_one(32'h5000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) retire_one();
    flush = 1'b1; flush_pack = 4'd7;
    rn_alloc = 1'b1; drive_fields(32'h6000);
    tick();
    idle();
    while (sb.size() > 4) void'(sb.pop_back());
    m_tail = 8;
    vectors++;
    if ({count, rn_pack, err} !== {5'd4, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL pflush_state: cnt=%0d pack=%0d err=%b, required cnt=4 pack=8 err=0", count, rn_pack, err);
    end
    for (int p = 4; p < 12; p++) begin
      pack = 4'(p);
      #1;
      vectors++;
      if (rd_vld !== (p < 8)) begin
        miscompares++;
        $display("FAIL pflush_vld[%0d]: got %b, required %b", p, rd_vld, p < 8);
      end
    end
    flush = 1'b1; flush_pack = 4'd4; cm_ret = 1'b1;
    tick();
    idle();
    sb.delete();
    m_head = 5; m_tail = 5;
    vectors++;
    if ({count, empty, head_pack, rn_pack, err} !== {5'd0, 1'b1, 4'd5, 4'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL pflush_ret_self: cnt=%0d empty=%b head=%0d pack=%0d err=%b, required 0 1 5 5 0",
               count, empty, head_pack, rn_pack, err);
    end
    for (int i = 0; i < 14; i++) alloc_one(32'h7000 + 32'(4 * i));
    flush = 1'b1; flush_pack = 4'd1;
    tick();
    idle();
    while (sb.size() > 13) void'(sb.pop_back());
    m_tail = 18;
    pack = 4'd1;
    #1;
    vectors++;
    if ({count, rn_pack, rd_vld, pc} !== {5'd13, 4'd2, 1'b1, sb[12]}) begin
      miscompares++;
      $display("FAIL pflush_wrap: cnt=%0d pack=%0d vld1=%b pc=%h, required cnt=13 pack=2 vld1=1 pc=%h",
               count, rn_pack, rd_vld, pc, sb[12]);
    end
    pack = 4'd2;
    #1;
    vectors++;
    if (rd_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL pflush_wrap_vld2: got %b, required 0", rd_vld);
    end
  endtask

  task automatic test_full_flush();
    for (int k = 0; k < 4; k++) begin
      pack = 4'(m_head);
      cm_ret = 1'b1;
      #1;
      exp_pc = sb.pop_front();
      vectors++;
      if (pc !== exp_pc) begin
        miscompares++;
        $display("FAIL ff_pre_ret_pc[%0d]: got %h, required %h", k, pc, exp_pc);
      end
      tick();
      m_head++;
    end
    full_flush = 1'b1; cm_ret = 1'b1; flush = 1'b1; flush_pack = 4'd10;
    rn_alloc = 1'b1; drive_fields(32'h8000);
    tick();
    idle();
    sb.delete();
    m_tail = m_head;
    vectors++;
    if ({count, empty, head_pack, rn_pack, err} !== {5'd0, 1'b1, 4'd9, 4'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL full_flush: cnt=%0d empty=%b head=%0d pack=%0d err=%b, required 0 1 9 9 0",
               count, empty, head_pack, rn_pack, err);
    end
    alloc_one(32'h9000);
    alloc_one(32'h9004);
    flush = 1'b1; flush_pack = 4'd3;
    tick();
    idle();
    vectors++;
    if ({err, count, rn_pack, head_pack} !== {1'b1, 5'd2, 4'd11, 4'd9}) begin
      miscompares++;
      $display("FAIL flush_invalid: err=%b cnt=%0d pack=%0d head=%0d, required 1 2 11 9", err, count, rn_pack, head_pack);
    end
  endtask

  task automatic test_parity();
    int bad;
    bad = -1;
`ifdef BINFO_PARITY_EN
    for (int i = 0; i < 8; i++) alloc_one(32'hA000 + 32'(4 * i));
    dut.par_q[2] = ~dut.par_q[2];
    bad = 2;
`endif
    for (int p = 0; p < DEPTH; p++) begin
      pack = 4'(p);
      #1;
      vectors++;
      if (rd_perr !== (p == bad)) begin
        miscompares++;
        $display("FAIL perr[%0d]: got %b, required %b", p, rd_perr, p == bad);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_read_retire();
    test_wrap();
    test_partial_flush();
    test_full_flush();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
